// File: rtl/switch_box_cfg.sv
// Programmable four-sided tri-state routing switch box with a serial,
// checksum-protected configuration loader that swaps in new routing atomically.
module switch_box_cfg #(
  parameter int NTB = 5,
  parameter int NLR = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_start,
  input  logic           cfg_valid,
  input  logic           cfg_bit,
  output logic           cfg_busy,
  output logic           cfg_done,
  output logic           cfg_err,
  output logic           cfg_loaded,
  inout  wire  [NTB-1:0] wtop,
  inout  wire  [NTB-1:0] wbottom,
  inout  wire  [NLR-1:0] wleft,
  inout  wire  [NLR-1:0] wright
);

  localparam int MAXN    = (NTB > NLR) ? NTB : NLR;
  localparam int IDXW    = (MAXN <= 1) ? 1 : $clog2(MAXN);
  localparam int EW      = IDXW + 3;
  localparam int NENT    = 2*NTB + 2*NLR;
  localparam int PAYLOAD = NENT * EW;
  localparam int CW      = $clog2(PAYLOAD + 8);
  localparam int PW      = $clog2(PAYLOAD);
  localparam int SW      = $clog2(NENT);

  typedef enum logic [1:0] {IDLE, SHIFT, VERIFY} state_t;

  // Handshake: a bit is consumed on every rising edge in SHIFT where
  // cfg_valid=1 and cfg_start=0; there is no back-pressure, cfg_busy is status only.
  state_t             state;
  logic [CW-1:0]      cnt;
  logic [7:0]         chk;
  logic [7:0]         rx_chk;
  logic [PAYLOAD-1:0] shadow;
  logic [PAYLOAD-1:0] active;
  logic [PW-1:0]      pidx;
  logic [CW-1:0]      roff;

  assign pidx     = cnt[PW-1:0];
  assign roff     = cnt - CW'(PAYLOAD);
  assign cfg_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      chk        <= '0;
      rx_chk     <= '0;
      shadow     <= '0;
      active     <= '0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_loaded <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      if (cfg_start) begin
        // Restart from any state; the bit offered this cycle is dropped.
        state <= SHIFT;
        cnt   <= '0;
        chk   <= '0;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          SHIFT: begin
            if (cfg_valid) begin
              if (cnt < CW'(PAYLOAD)) begin
                shadow[pidx]  <= cfg_bit;
                chk[cnt[2:0]] <= chk[cnt[2:0]] ^ cfg_bit;
              end else begin
                rx_chk[roff[2:0]] <= cfg_bit;
              end
              cnt <= cnt + CW'(1);
              if (cnt == CW'(PAYLOAD + 7)) state <= VERIFY;
            end
          end
          VERIFY: begin
            if (chk == rx_chk) begin
              active     <= shadow;
              cfg_done   <= 1'b1;
              cfg_loaded <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Pins flattened in entry order: top, bottom, left, right.
  logic [NENT-1:0] pin_in;
  logic [NENT-1:0] drv_en;
  logic [NENT-1:0] drv_val;

  assign pin_in = {wright, wleft, wbottom, wtop};

  always_comb begin : p_route
    logic [2:0]      side;
    logic [IDXW-1:0] idx;
    int              src;
    logic [SW-1:0]   srcv;
    drv_en  = '0;
    drv_val = '0;
    for (int k = 0; k < NENT; k++) begin
      side = active[k*EW +: 3];
      idx  = active[k*EW+3 +: IDXW];
      src  = -1;
      case (side)
        3'd1: if (int'(idx) < NTB) src = int'(idx);
        3'd2: if (int'(idx) < NLR) src = 2*NTB + NLR + int'(idx);
        3'd3: if (int'(idx) < NTB) src = NTB + int'(idx);
        3'd4: if (int'(idx) < NLR) src = 2*NTB + int'(idx);
        default: src = -1;
      endcase
      srcv = SW'(src);
      if (src >= 0 && src != k) begin
        drv_en[k]  = 1'b1;
        drv_val[k] = pin_in[srcv];
      end
    end
  end

  for (genvar i = 0; i < NTB; i++) begin : g_tb_pins
    assign wtop[i]    = drv_en[i]       ? drv_val[i]       : 1'bz;
    assign wbottom[i] = drv_en[NTB + i] ? drv_val[NTB + i] : 1'bz;
  end

  for (genvar i = 0; i < NLR; i++) begin : g_lr_pins
    assign wleft[i]  = drv_en[2*NTB + i]       ? drv_val[2*NTB + i]       : 1'bz;
    assign wright[i] = drv_en[2*NTB + NLR + i] ? drv_val[2*NTB + NLR + i] : 1'bz;
  end

endmodule
